// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU command dispatcher.
// Opcode map, state encoding and command bundle layout.
package alu_pkg;

  localparam int A_W   = 16;
  localparam int B_W   = 16;
  localparam int OP_W  = 4;
  localparam int RES_W = 32;

  localparam logic [OP_W-1:0] OP_ADD = 4'h0;
  localparam logic [OP_W-1:0] OP_SUB = 4'h1;
  localparam logic [OP_W-1:0] OP_MUL = 4'h2;
  localparam logic [OP_W-1:0] OP_DIV = 4'h3;
  localparam logic [OP_W-1:0] OP_AND = 4'h4;
  localparam logic [OP_W-1:0] OP_OR  = 4'h5;
  localparam logic [OP_W-1:0] OP_XOR = 4'h6;
  localparam logic [OP_W-1:0] OP_NOT = 4'h7;
  localparam logic [OP_W-1:0] OP_SHL = 4'h8;
  localparam logic [OP_W-1:0] OP_SHR = 4'h9;
  localparam logic [OP_W-1:0] OP_SRA = 4'hA;
  localparam logic [OP_W-1:0] OP_MAX_LEGAL = 4'hA;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  typedef struct packed {
    logic [A_W-1:0]  a;
    logic [B_W-1:0]  b;
    logic [OP_W-1:0] op;
  } cmd_t;

  function automatic logic op_legal(
    input logic [OP_W-1:0] op
  );
    return op <= OP_MAX_LEGAL;
  endfunction

endpackage

// File: rtl/alu_cmd_dispatcher_if.sv
// Command, calculator and response signals of the dispatcher.
// slave = dispatcher view, master = environment view.
interface alu_cmd_dispatcher_if;
  import alu_pkg::*;

  logic             cmd_valid;
  logic             cmd_ready;
  logic [A_W-1:0]   cmd_a;
  logic [B_W-1:0]   cmd_b;
  logic [OP_W-1:0]  cmd_op;
  logic             alu_start;
  logic [A_W-1:0]   alu_a;
  logic [B_W-1:0]   alu_b;
  logic [OP_W-1:0]  alu_op;
  logic [RES_W-1:0] alu_result;
  logic             alu_done;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [RES_W-1:0] rsp_result;
  logic [OP_W-1:0]  rsp_op;
  logic             rsp_err;
  logic             busy;

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op,
    input  alu_result, alu_done, rsp_ready,
    output cmd_ready, alu_start,
    output alu_a, alu_b, alu_op,
    output rsp_valid, rsp_result, rsp_op,
    output rsp_err, busy
  );

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op,
    output alu_result, alu_done, rsp_ready,
    input  cmd_ready, alu_start,
    input  alu_a, alu_b, alu_op,
    input  rsp_valid, rsp_result, rsp_op,
    input  rsp_err, busy
  );

endinterface

// File: rtl/alu_cmd_fifo.sv
// Command FIFO: DEPTH entries of packed cmd_t.
// Extra pointer MSB separates full from empty.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  cmd_t wdata,
  output cmd_t rdata,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  cmd_t        mem [DEPTH];
  logic [AW:0] wptr;
  logic [AW:0] rptr;
  logic        do_push;
  logic        do_pop;

  assign empty = wptr == rptr;
  assign full  = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/alu_cmd_dispatcher.sv
// Queues ALU commands and runs them one at a time
// through the calculator start/done handshake.
module alu_cmd_dispatcher
  import alu_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input logic clk,
  input logic reset,
  alu_cmd_dispatcher_if.slave bus
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [1:0]    state;
  logic [CW-1:0] tmo_cnt;
  cmd_t          wdata;
  cmd_t          head;
  logic          full;
  logic          empty;
  logic          pop;

  assign wdata = '{a: bus.cmd_a, b: bus.cmd_b, op: bus.cmd_op};
  assign pop   = (state == ST_IDLE) && !empty;

  alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (bus.cmd_valid),
    .pop   (pop),
    .wdata (wdata),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  assign bus.cmd_ready = !full;
  assign bus.alu_start = state == ST_ISSUE;
  assign bus.rsp_valid = state == ST_RESP;
  assign bus.busy      = (state != ST_IDLE) || !empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      tmo_cnt        <= '0;
      bus.alu_a      <= '0;
      bus.alu_b      <= '0;
      bus.alu_op     <= '0;
      bus.rsp_result <= '0;
      bus.rsp_op     <= '0;
      bus.rsp_err    <= 1'b0;
    end else begin
      unique case (1'b1)
        state == ST_IDLE: begin
          if (!empty) begin
            bus.alu_a  <= head.a;
            bus.alu_b  <= head.b;
            bus.alu_op <= head.op;
            if (op_legal(head.op)) begin
              state <= ST_ISSUE;
            end else begin
              // illegal op never reaches the calculator
              bus.rsp_result <= '0;
              bus.rsp_op     <= head.op;
              bus.rsp_err    <= 1'b1;
              state          <= ST_RESP;
            end
          end
        end
        state == ST_ISSUE: begin
          tmo_cnt <= '0;
          state   <= ST_WAIT;
        end
        state == ST_WAIT: begin
          if (bus.alu_done) begin
            bus.rsp_result <= bus.alu_result;
            bus.rsp_op     <= bus.alu_op;
            bus.rsp_err    <= 1'b0;
            state          <= ST_RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
            if (tmo_cnt == CW'(TIMEOUT - 1)) begin
              bus.rsp_result <= '0;
              bus.rsp_op     <= bus.alu_op;
              bus.rsp_err    <= 1'b1;
              state          <= ST_RESP;
            end
          end
        end
        state == ST_RESP: begin
          if (bus.rsp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
